ps2_key_commander: RTL and testbench

- Receives PS/2 keyboard frames and decodes make/break/extended scancodes.
- Drives the sequencer UI control interface: Direction (one-hot), Command, start_playback and play_enable.
- Sits between the board PS2_CLK/PS2_DAT pins and the grid/playback display controller.
- Converts typematic keyboard traffic into clean single-cycle command pulses and a level playback enable.

---
 rtl/ps2_key_commander.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_key_commander.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_commander.sv
// ps2_key_commander
//   Receives PS/2 keyboard frames, decodes make/break/extended scancodes and
//   turns them into clean sequencer UI controls. Key auto-repeat is suppressed,
//   so every physical key press produces exactly one action.
//
// Ports
//   CLOCK_50        in   system clock (50 MHz)
//   nReset          in   asynchronous active-low reset
//   PS2_CLK         in   keyboard clock (asynchronous)
//   PS2_DAT         in   keyboard data (asynchronous)
//   Direction[3:0]  out  one-hot move pulse: UP=0001 DOWN=0010 LEFT=0100 RIGHT=1000
//   Command         out  one-cycle draw/toggle pulse (Space)
//   start_playback  out  one-cycle playback start pulse (Enter while stopped)
//   play_enable     out  playback level (set by Enter, cleared by Esc)
//   rx_error        out  one-cycle pulse when a frame is discarded
module ps2_key_commander #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] Direction,
  output logic       Command,
  output logic       start_playback,
  output logic       play_enable,
  output logic       rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BREAK, DEC_EXT_BREAK} dec_state_t;

  // Held-flag indices; arrows share their index with the Direction bit.
  localparam logic [2:0] K_UP    = 3'd0;
  localparam logic [2:0] K_DOWN  = 3'd1;
  localparam logic [2:0] K_LEFT  = 3'd2;
  localparam logic [2:0] K_RIGHT = 3'd3;
  localparam logic [2:0] K_SPACE = 3'd4;
  localparam logic [2:0] K_ENTER = 3'd5;
  localparam logic [2:0] K_ESC   = 3'd6;
  localparam logic [2:0] K_NONE  = 3'd7;

  function automatic logic [2:0] key_index(input logic ext, input logic [7:0] code);
    key_index = K_NONE;
    if (ext) begin
      case (code)
        8'h75:   key_index = K_UP;
        8'h72:   key_index = K_DOWN;
        8'h6B:   key_index = K_LEFT;
        8'h74:   key_index = K_RIGHT;
        default: key_index = K_NONE;
      endcase
    end else begin
      case (code)
        8'h29:   key_index = K_SPACE;
        8'h5A:   key_index = K_ENTER;
        8'h76:   key_index = K_ESC;
        default: key_index = K_NONE;
      endcase
    end
  endfunction

  logic          ps2c_s1_q, ps2c_s1_d, ps2c_s2_q, ps2c_s2_d;
  logic          ps2d_s1_q, ps2d_s1_d, ps2d_s2_q, ps2d_s2_d;
  logic          filt_clk_q, filt_clk_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;
  rx_state_t     rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          rx_err_q, rx_err_d;
  dec_state_t    dec_state_q, dec_state_d;
  logic [6:0]    held_q, held_d;
  logic [3:0]    dir_q, dir_d;
  logic          cmd_q, cmd_d, start_q, start_d, play_q, play_d;
  logic          ext_mode, brk_mode;
  logic [2:0]    key;

  // Stage 0: synchronizers, clock glitch filter, falling-edge detect
  always_comb begin
    ps2c_s1_d   = PS2_CLK;
    ps2c_s2_d   = ps2c_s1_q;
    ps2d_s1_d   = PS2_DAT;
    ps2d_s2_d   = ps2d_s1_q;
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    filt_prev_d = filt_clk_q;
    // The counter only runs while the sampled clock disagrees with the filtered
    // level, so any agreeing sample restarts the qualification window.
    if (ps2c_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = ~filt_clk_q;
      else                                   filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  assign fall = filt_prev_q & ~filt_clk_q;

  // Stage 1: frame receiver
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;
    if (rx_state_q == RX_IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d   = '0;
      rx_state_d = RX_IDLE;
      rx_err_d   = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    if (fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          // A high data bit here is line noise, not a start bit.
          if (!ps2d_s2_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = 3'd0;
            par_d      = 1'b0;
          end
        end
        RX_DATA: begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          par_d     = par_q ^ ps2d_s2_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d      = par_q ^ ps2d_s2_q;
          rx_state_d = RX_STOP;
        end
        default: begin
          rx_state_d = RX_IDLE;
          if (par_q && ps2d_s2_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Stage 2: scancode decoder, typematic suppression and registered outputs
  always_comb begin
    dec_state_d = dec_state_q;
    held_d      = held_q;
    dir_d       = '0;
    cmd_d       = 1'b0;
    start_d     = 1'b0;
    play_d      = play_q;
    ext_mode    = (dec_state_q == DEC_EXT) || (dec_state_q == DEC_EXT_BREAK);
    brk_mode    = (dec_state_q == DEC_BREAK) || (dec_state_q == DEC_EXT_BREAK);
    key         = key_index(ext_mode, byte_q);
    if (rx_err_q) begin
      // A lost byte may have been a prefix; never apply stale E0/F0 context.
      dec_state_d = DEC_IDLE;
    end else if (byte_valid_q) begin
      if (dec_state_q == DEC_IDLE && byte_q == 8'hE0) begin
        dec_state_d = DEC_EXT;
      end else if (byte_q == 8'hF0 && dec_state_q == DEC_IDLE) begin
        dec_state_d = DEC_BREAK;
      end else if (byte_q == 8'hF0 && dec_state_q == DEC_EXT) begin
        dec_state_d = DEC_EXT_BREAK;
      end else begin
        dec_state_d = DEC_IDLE;
        if (key != K_NONE) begin
          if (brk_mode) begin
            held_d[key] = 1'b0;
          end else if (!held_q[key]) begin
            held_d[key] = 1'b1;
            case (key)
              K_SPACE: cmd_d = 1'b1;
              K_ENTER: begin
                if (!play_q) begin
                  start_d = 1'b1;
                  play_d  = 1'b1;
                end
              end
              K_ESC:   play_d = 1'b0;
              default: dir_d[key[1:0]] = 1'b1;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      ps2c_s1_q    <= 1'b1;
      ps2c_s2_q    <= 1'b1;
      ps2d_s1_q    <= 1'b1;
      ps2d_s2_q    <= 1'b1;
      filt_clk_q   <= 1'b1;
      filt_prev_q  <= 1'b1;
      filt_cnt_q   <= '0;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      dec_state_q  <= DEC_IDLE;
      held_q       <= '0;
      dir_q        <= '0;
      cmd_q        <= 1'b0;
      start_q      <= 1'b0;
      play_q       <= 1'b0;
    end else begin
      ps2c_s1_q    <= ps2c_s1_d;
      ps2c_s2_q    <= ps2c_s2_d;
      ps2d_s1_q    <= ps2d_s1_d;
      ps2d_s2_q    <= ps2d_s2_d;
      filt_clk_q   <= filt_clk_d;
      filt_prev_q  <= filt_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
      dec_state_q  <= dec_state_d;
      held_q       <= held_d;
      dir_q        <= dir_d;
      cmd_q        <= cmd_d;
      start_q      <= start_d;
      play_q       <= play_d;
    end
  end

  // Data-only registers; their contents are qualified by byte_valid_q.
  always_ff @(posedge CLOCK_50) begin
    shift_q <= shift_d;
    byte_q  <= byte_d;
  end

  assign Direction      = dir_q;
  assign Command        = cmd_q;
  assign start_playback = start_q;
  assign play_enable    = play_q;
  assign rx_error       = rx_err_q;

endmodule

// File: tb/tb_ps2_key_commander.sv
module tb_ps2_key_commander;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 50000;
  localparam int HALF           = 14;
  // synchronizer (2) + filter (FILTER_LEN) + edge detect/byte_valid (1) + output reg (1)
  localparam int LAT            = 2 + FILTER_LEN + 2;

  logic       CLOCK_50 = 1'b0;
  logic       nReset   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [3:0] Direction;
  logic       Command, start_playback, play_enable, rx_error;

  ps2_key_commander #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .Direction(Direction), .Command(Command), .start_playback(start_playback),
    .play_enable(play_enable), .rx_error(rx_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Output monitor: counts high cycles of every pulse output
  int         dir_hi [4] = '{default: 0};
  int         cmd_hi = 0, start_hi = 0, err_hi = 0, viol = 0;
  int         dir_cyc = 0, err_cyc = 0;
  logic [3:0] dir_val = 4'b0;

  always @(negedge CLOCK_50) begin
    if (nReset) begin
      for (int i = 0; i < 4; i++) if (Direction[i]) dir_hi[i] <= dir_hi[i] + 1;
      if (Direction != 4'b0) begin
        dir_cyc <= cyc;
        dir_val <= Direction;
      end
      if (Command)        cmd_hi   <= cmd_hi + 1;
      if (start_playback) start_hi <= start_hi + 1;
      if (rx_error) begin
        err_hi  <= err_hi + 1;
        err_cyc <= cyc;
      end
      if ($countones(Direction) > 1 ||
          (int'(Direction != 4'b0) + int'(Command) + int'(start_playback)) > 1)
        viol <= viol + 1;
    end
  end

  int checks = 0, errors = 0;

  // Reference model: keyboard byte stream -> expected action totals
  bit   m_ext = 0, m_brk = 0;
  bit   m_held [7] = '{default: 0};
  int   e_dir [4] = '{default: 0};
  int   e_cmd = 0, e_start = 0;
  bit   e_play = 0;
  logic [7:0] pool [10] = '{8'h29, 8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'hAA, 8'hFA};

  function automatic int key_id(input bit ext, input logic [7:0] code);
    if (ext && code == 8'h75) return 0;
    if (ext && code == 8'h72) return 1;
    if (ext && code == 8'h6B) return 2;
    if (ext && code == 8'h74) return 3;
    if (!ext && code == 8'h29) return 4;
    if (!ext && code == 8'h5A) return 5;
    if (!ext && code == 8'h76) return 6;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int id;
    if (!m_ext && !m_brk && b == 8'hE0) m_ext = 1;
    else if (!m_brk && b == 8'hF0) m_brk = 1;
    else begin
      id = key_id(m_ext, b);
      if (id >= 0) begin
        if (m_brk) m_held[id] = 0;
        else if (!m_held[id]) begin
          m_held[id] = 1;
          if (id < 4) e_dir[id]++;
          else if (id == 4) e_cmd++;
          else if (id == 5) begin
            if (!e_play) begin
              e_start++;
              e_play = 1;
            end
          end else e_play = 0;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_abort();
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_reset();
    model_abort();
    for (int i = 0; i < 7; i++) m_held[i] = 0;
    e_play = 0;
  endtask

  // Keyboard driver
  int last_fall = 0, stop_fall = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tick(HALF / 2);
    PS2_DAT = b;
    tick(HALF - HALF / 2);
    PS2_CLK = 1'b0;
    last_fall = cyc;
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    stop_fall = last_fall;
    PS2_DAT = 1'b1;
    tick(30);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(5);
    checks++;
    if ({Direction, Command, start_playback, play_enable, rx_error} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected 00", {Direction, Command, start_playback, play_enable, rx_error});
    end
    nReset = 1'b1;
    tick(20);
    checks++;
    if ({Direction, Command, start_playback, play_enable, rx_error} !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: outputs=%h expected 00", {Direction, Command, start_playback, play_enable, rx_error});
    end
  endtask

  task automatic test_arrow_up();
    int u0, o0, f2;
    u0 = dir_hi[0];
    o0 = dir_hi[1] + dir_hi[2] + dir_hi[3];
    send_byte(8'hE0);
    send_byte(8'h75);
    f2 = stop_fall;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++;
    if (dir_hi[0] - u0 !== 1) begin
      errors++; $display("FAIL up_count: got %0d expected 1", dir_hi[0] - u0);
    end
    checks++;
    if (dir_cyc - f2 !== LAT) begin
      errors++; $display("FAIL up_latency: got %0d expected %0d", dir_cyc - f2, LAT);
    end
    checks++;
    if (dir_val !== 4'b0001) begin
      errors++; $display("FAIL up_value: got %b expected 0001", dir_val);
    end
    checks++;
    if (dir_hi[1] + dir_hi[2] + dir_hi[3] - o0 !== 0) begin
      errors++; $display("FAIL up_others: got %0d expected 0", dir_hi[1] + dir_hi[2] + dir_hi[3] - o0);
    end
  endtask

  task automatic test_space();
    int c0, e0;
    c0 = cmd_hi;
    e0 = err_hi;
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'h29);
    checks++;
    if (cmd_hi - c0 !== 2) begin
      errors++; $display("FAIL space_count: got %0d expected 2", cmd_hi - c0);
    end
    checks++;
    if (err_hi - e0 !== 0) begin
      errors++; $display("FAIL space_rx_error: got %0d expected 0", err_hi - e0);
    end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_enter();
    int s0;
    s0 = start_hi;
    send_byte(8'h5A);
    checks++;
    if (play_enable !== 1'b1) begin
      errors++; $display("FAIL enter_play_on: got %b expected 1", play_enable);
    end
    send_byte(8'hF0); send_byte(8'h5A);
    send_byte(8'h5A);
    checks++;
    if (play_enable !== 1'b1) begin
      errors++; $display("FAIL enter_play_hold: got %b expected 1", play_enable);
    end
    send_byte(8'h76);
    checks++;
    if (play_enable !== 1'b0) begin
      errors++; $display("FAIL esc_play_off: got %b expected 0", play_enable);
    end
    checks++;
    if (start_hi - s0 !== 1) begin
      errors++; $display("FAIL enter_start_count: got %0d expected 1", start_hi - s0);
    end
    send_byte(8'hF0); send_byte(8'h5A);
    send_byte(8'hF0); send_byte(8'h76);
  endtask

  task automatic test_bad_frames();
    int e0, l0, c0;
    e0 = err_hi;
    l0 = dir_hi[2];
    c0 = cmd_hi;
    send_byte(8'hE0);
    send_frame(8'h6B, 1'b1, 1'b0);
    model_abort();
    checks++;
    if (err_hi - e0 !== 1) begin
      errors++; $display("FAIL parity_err_count: got %0d expected 1", err_hi - e0);
    end
    checks++;
    if (err_cyc - stop_fall !== LAT - 1) begin
      errors++; $display("FAIL parity_err_latency: got %0d expected %0d", err_cyc - stop_fall, LAT - 1);
    end
    checks++;
    if (dir_hi[2] - l0 !== 0) begin
      errors++; $display("FAIL parity_no_dir: got %0d expected 0", dir_hi[2] - l0);
    end
    send_byte(8'hE0); send_byte(8'h6B);
    checks++;
    if (dir_hi[2] - l0 !== 1 || dir_val !== 4'b0100) begin
      errors++; $display("FAIL left_after_err: count %0d value %b expected 1 0100", dir_hi[2] - l0, dir_val);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    send_frame(8'h29, 1'b0, 1'b1);
    model_abort();
    checks++;
    if (err_hi - e0 !== 2 || cmd_hi - c0 !== 0) begin
      errors++; $display("FAIL stop_err: errs %0d cmds %0d expected 2 0", err_hi - e0, cmd_hi - c0);
    end
  endtask

  task automatic test_timeout();
    int e0, c0, f, n;
    e0 = err_hi;
    c0 = cmd_hi;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    f = last_fall;
    PS2_DAT = 1'b1;
    n = 0;
    while (err_hi == e0 && n < 60000) begin
      tick(1);
      n++;
    end
    model_abort();
    checks++;
    if (err_hi - e0 !== 1) begin
      errors++; $display("FAIL timeout_err_count: got %0d expected 1", err_hi - e0);
    end
    checks++;
    if (err_cyc - f < TIMEOUT_CYCLES || err_cyc - f > TIMEOUT_CYCLES + LAT + 2) begin
      errors++; $display("FAIL timeout_err_time: got %0d expected about %0d", err_cyc - f, TIMEOUT_CYCLES);
    end
    tick(20);
    send_byte(8'h29);
    checks++;
    if (cmd_hi - c0 !== 1) begin
      errors++; $display("FAIL timeout_recover: got %0d expected 1", cmd_hi - c0);
    end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_glitch();
    int t0, c0;
    t0 = dir_hi[0] + dir_hi[1] + dir_hi[2] + dir_hi[3] + cmd_hi + start_hi + err_hi;
    c0 = cmd_hi;
    PS2_DAT = 1'b0;
    repeat (4) begin
      PS2_CLK = 1'b0;
      tick(5);
      PS2_CLK = 1'b1;
      tick(20);
    end
    PS2_DAT = 1'b1;
    tick(20);
    checks++;
    if (dir_hi[0] + dir_hi[1] + dir_hi[2] + dir_hi[3] + cmd_hi + start_hi + err_hi - t0 !== 0) begin
      errors++; $display("FAIL glitch_quiet: got %0d pulses expected 0",
                         dir_hi[0] + dir_hi[1] + dir_hi[2] + dir_hi[3] + cmd_hi + start_hi + err_hi - t0);
    end
    send_byte(8'h29);
    checks++;
    if (cmd_hi - c0 !== 1) begin
      errors++; $display("FAIL glitch_then_frame: got %0d expected 1", cmd_hi - c0);
    end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_random();
    int kind;
    logic [7:0] code;
    for (int it = 0; it < 20; it++) begin
      kind = int'($urandom_range(0, 3));
      code = pool[$urandom_range(0, 9)];
      if (kind >= 2) send_byte(8'hE0);
      if (kind == 1 || kind == 3) send_byte(8'hF0);
      send_byte(code);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dir_hi[i] !== e_dir[i]) begin
          errors++; $display("FAIL rand_dir%0d it%0d: got %0d expected %0d", i, it, dir_hi[i], e_dir[i]);
        end
      end
      checks++;
      if (cmd_hi !== e_cmd) begin
        errors++; $display("FAIL rand_cmd it%0d: got %0d expected %0d", it, cmd_hi, e_cmd);
      end
      checks++;
      if (start_hi !== e_start) begin
        errors++; $display("FAIL rand_start it%0d: got %0d expected %0d", it, start_hi, e_start);
      end
      checks++;
      if (play_enable !== e_play) begin
        errors++; $display("FAIL rand_play it%0d: got %b expected %b", it, play_enable, e_play);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int u0;
    send_byte(8'hF0); send_byte(8'h5A); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    checks++;
    if (play_enable !== 1'b1) begin
      errors++; $display("FAIL pre_reset_play: got %b expected 1", play_enable);
    end
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    nReset = 1'b0;
    model_reset();
    tick(3);
    checks++;
    if ({Direction, Command, start_playback, play_enable, rx_error} !== 8'h00) begin
      errors++; $display("FAIL midframe_reset_out: outputs=%h expected 00", {Direction, Command, start_playback, play_enable, rx_error});
    end
    PS2_DAT = 1'b1;
    nReset = 1'b1;
    tick(20);
    u0 = dir_hi[0];
    send_byte(8'h75);
    checks++;
    if (dir_hi[0] - u0 !== 0) begin
      errors++; $display("FAIL post_reset_75: got %0d expected 0", dir_hi[0] - u0);
    end
    send_byte(8'hE0); send_byte(8'h75);
    checks++;
    if (dir_hi[0] - u0 !== 1) begin
      errors++; $display("FAIL held_cleared: got %0d expected 1", dir_hi[0] - u0);
    end
    checks++;
    if (play_enable !== 1'b0) begin
      errors++; $display("FAIL post_reset_play: got %b expected 0", play_enable);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL exclusive_outputs: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_arrow_up();
    test_space();
    test_enter();
    test_bad_frames();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_midframe();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
